// File: rtl/spi_config_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_config_master
// Description : Mode-0 SPI master that sends a 32-bit configuration word and
//               captures the 32-bit reply, MSB first, with an inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_config_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx_data,
    output logic        ss,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    localparam int                   c_phase_w    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_phase_w-1:0] c_phase_last = c_phase_w'(CLK_DIV - 1);
    localparam logic [c_phase_w-1:0] c_phase_one  = c_phase_w'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_TRAIL = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t                 r_state,   w_state;
    logic [c_phase_w-1:0]   r_phase,   w_phase;
    logic [4:0]             r_bit,     w_bit;
    logic [30:0]            r_tx,      w_tx;
    logic [31:0]            r_rx,      w_rx;
    logic [31:0]            r_rx_data, w_rx_data;
    logic                   r_ss,      w_ss;
    logic                   r_sclk,    w_sclk;
    logic                   r_mosi,    w_mosi;
    logic                   r_busy,    w_busy;
    logic                   r_done,    w_done;
    logic                   w_phase_end;
    logic                   w_accept;

    assign w_phase_end = (r_phase == c_phase_last);
    // The GAP-ending edge may accept a new frame directly, giving a 66*D period.
    assign w_accept    = start && ((r_state == S_IDLE) || ((r_state == S_GAP) && w_phase_end));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_ss      <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_phase   <= w_phase;
            r_bit     <= w_bit;
            r_tx      <= w_tx;
            r_rx      <= w_rx;
            r_rx_data <= w_rx_data;
            r_ss      <= w_ss;
            r_sclk    <= w_sclk;
            r_mosi    <= w_mosi;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_phase   = r_phase;
        w_bit     = r_bit;
        w_tx      = r_tx;
        w_rx      = r_rx;
        w_rx_data = r_rx_data;
        w_ss      = r_ss;
        w_sclk    = r_sclk;
        w_mosi    = r_mosi;
        w_busy    = r_busy;
        w_done    = 1'b0;

        if (r_state != S_IDLE) begin
            w_phase = w_phase_end ? '0 : (r_phase + c_phase_one);
        end

        case (r_state)
            S_IDLE: begin
            end
            S_LEAD: begin
                if (w_phase_end) begin
                    w_state = S_HIGH;
                    w_sclk  = 1'b1;
                end
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_rx   = {r_rx[30:0], miso};
                    w_sclk = 1'b0;
                    if (r_bit == 5'd31) begin
                        w_state = S_TRAIL;
                    end else begin
                        w_state = S_LOW;
                        w_bit   = r_bit + 5'd1;
                        w_mosi  = r_tx[30];
                        w_tx    = {r_tx[29:0], 1'b0};
                    end
                end
            end
            S_LOW: begin
                if (w_phase_end) begin
                    w_state = S_HIGH;
                    w_sclk  = 1'b1;
                end
            end
            S_TRAIL: begin
                if (w_phase_end) begin
                    w_state   = S_GAP;
                    w_ss      = 1'b1;
                    w_rx_data = r_rx;
                    w_done    = 1'b1;
                end
            end
            S_GAP: begin
                if (w_phase_end) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // The TX register keeps only the bits still to be sent after the MSB.
        if (w_accept) begin
            w_state = S_LEAD;
            w_phase = '0;
            w_bit   = '0;
            w_tx    = tx_data[30:0];
            w_mosi  = tx_data[31];
            w_ss    = 1'b0;
            w_sclk  = 1'b0;
            w_busy  = 1'b1;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign ss      = r_ss;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;

endmodule
`default_nettype wire
